// File: rtl/gh_fifo_pkg.sv
// Shared definitions for the gh FIFO pointer controllers: default address
// width, pointer type and the binary-to-Gray helper used by both the read
// and write sides.
package gh_fifo_pkg;

    // Default RAM address width; FIFO depth is 2**DEF_ADDR_W.
    localparam int DEF_ADDR_W = 4;

    // Pointer with one extra MSB acting as the wrap bit.
    typedef logic [DEF_ADDR_W:0] ptr_t;

    // Binary to Gray on a 32-bit container; callers size-cast to their width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gh_gray2binary.sv
// Parameterized combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at and above its position.
module gh_gray2binary #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Prefix-XOR from the MSB down, written as a reduction per bit.
    always_comb begin
        // NOTE: assigning a default before the loop keeps every bit driven on every pass, so no latch is inferred.
        bin = '0;
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/gh_fifo_rd_ctrl.sv
// Read-side pointer controller for the UART asynchronous FIFOs.
// Synchronizes the Gray write pointer into the read domain, keeps the read
// pointer, and produces the RAM read address, empty, count and underflow.
// Optional macro GH_FIFO_SYNC3_EN selects a 3-flop synchronizer (default 2).
module gh_fifo_rd_ctrl
    import gh_fifo_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic [ADDR_W:0]   wr_gray_i,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   rd_gray_o,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              underflow
);

    localparam int PW = ADDR_W + 1;

`ifdef GH_FIFO_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] wr_gray_s;
    logic [PW-1:0] wr_bin_s;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_bin_next;
    logic          accept;

    // Plain flop chain carrying the write pointer into the read domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates make every stage sample its pre-edge input, so the chain shifts one stage per clock.
            sync_q[0] <= wr_gray_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wr_gray_s = sync_q[SYNC_STAGES-1];

    gh_gray2binary #(
        .W (PW)
    ) u_wr_g2b (
        .gray (wr_gray_s),
        .bin  (wr_bin_s)
    );

    // A read is accepted only when data is present; the pointer wraps naturally.
    assign accept      = rd && !empty;
    assign rd_bin_next = accept ? rd_bin + PW'(1) : rd_bin;

    // Read pointer, its Gray image and the underflow pulse share one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bin    <= '0;
            rd_gray_o <= '0;
            underflow <= 1'b0;
        end else begin
            rd_bin    <= rd_bin_next;
            rd_gray_o <= PW'(bin2gray(32'(rd_bin_next)));
            underflow <= rd && empty;
        end
    end

    // Status is decoded from registered pointers only.
    assign empty   = (rd_gray_o == wr_gray_s);
    assign count   = wr_bin_s - rd_bin;
    assign rd_addr = rd_bin[ADDR_W-1:0];

endmodule
